encoder4to2_en_n: RTL and testbench

- Registered 4-to-2 encoder with active-low request inputs and an active-low enable.
- Converts a single asserted (low) request line into its 2-bit binary index, with valid and error qualifiers.
- Used as a small front-end encoder where request/enable signals are active-low.
- Outputs are registered: one clock of latency from input to output.

---
 rtl/encoder4to2_en_n.sv | 130 +++++++++++++
 tb/tb_encoder4to2_en_n.sv | 125 ++++++++++++
 2 files changed

// File: rtl/encoder4to2_en_n.sv
// encoder4to2_en_n
//
// Registered 4-to-2 encoder with active-low request lines and an active-low
// enable. A single active request is encoded to its 2-bit index. Several
// active requests are flagged on err. In strict mode (PRIORITY_MODE = 0) that
// case produces no encoding. In priority mode (PRIORITY_MODE = 1) the highest
// active index is encoded and valid is still asserted. Every output is
// registered, so inputs sampled at one rising edge appear right after it.
//
// Parameters:
//   PRIORITY_MODE  0 = strict one-hot, 1 = highest active index wins
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous reset, active-high, overrides everything
//   e      in   1  enable, active-low (0 = encoder enabled)
//   w      in   4  request lines, active-low (w[i] = 0 means request i active)
//   y      out  2  encoded index of the active request
//   valid  out  1  y holds a legitimate encoding
//   err    out  1  more than one request active while enabled

module encoder4to2_en_n #(
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic [3:0] w,
    output logic [1:0] y,
    output logic       valid,
    output logic       err
);

    // Active-high view of the request lines.
    logic [3:0] act;
    logic [2:0] act_count;
    logic       enabled;
    logic       none_active;
    logic       one_active;
    logic       multi_active;
    logic [1:0] onehot_idx;
    logic [1:0] prio_idx;

    logic [1:0] y_d;
    logic       valid_d;
    logic       err_d;

    logic [1:0] y_q;
    logic       valid_q;
    logic       err_q;

    assign act     = ~w;
    assign enabled = ~e;

    // Number of active requests; only its zero, one, many class matters.
    assign act_count = {2'b00, act[0]} + {2'b00, act[1]} +
                       {2'b00, act[2]} + {2'b00, act[3]};

    assign none_active  = (act_count == 3'd0);
    assign one_active   = (act_count == 3'd1);
    assign multi_active = (act_count >= 3'd2);

    // Index of the single active line. Used only when exactly one line is
    // active, so any other input pattern falls to the default.
    always_comb begin
        onehot_idx = 2'b00;
        unique case (act)
            4'b0001: onehot_idx = 2'd0;
            4'b0010: onehot_idx = 2'd1;
            4'b0100: onehot_idx = 2'd2;
            4'b1000: onehot_idx = 2'd3;
            default: onehot_idx = 2'b00;
        endcase
    end

    // Highest active index; bit 3 has the highest priority.
    always_comb begin
        prio_idx = 2'b00;
        if (act[3]) begin
            prio_idx = 2'd3;
        end else if (act[2]) begin
            prio_idx = 2'd2;
        end else if (act[1]) begin
            prio_idx = 2'd1;
        end else begin
            prio_idx = 2'd0;
        end
    end

    // Next-state outputs. Each edge fully recomputes from e and w, so no
    // state survives beyond the single output register stage.
    always_comb begin
        y_d     = 2'b00;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (enabled) begin
            if (one_active) begin
                y_d     = onehot_idx;
                valid_d = 1'b1;
            end else if (multi_active) begin
                err_d = 1'b1;
                if (PRIORITY_MODE != 0) begin
                    y_d     = prio_idx;
                    valid_d = 1'b1;
                end
            end else if (none_active) begin
                // Idle: nothing to encode, outputs remain at their defaults.
                y_d     = 2'b00;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= 2'b00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_encoder4to2_en_n.sv
// Directed bench for encoder4to2_en_n. Both parameter settings are
// instantiated side by side on shared stimulus; every step is checked against
// hand-computed expected {y, valid, err} for each instance.

module tb_encoder4to2_en_n;

    logic       clk;
    logic       rst;
    logic       e;
    logic [3:0] w;

    logic [1:0] y_s;
    logic       valid_s;
    logic       err_s;
    logic [1:0] y_p;
    logic       valid_p;
    logic       err_p;

    int checks;
    int failures;

    encoder4to2_en_n #(
        .PRIORITY_MODE(0)
    ) u_strict (
        .clk  (clk),
        .rst  (rst),
        .e    (e),
        .w    (w),
        .y    (y_s),
        .valid(valid_s),
        .err  (err_s)
    );

    encoder4to2_en_n #(
        .PRIORITY_MODE(1)
    ) u_prio (
        .clk  (clk),
        .rst  (rst),
        .e    (e),
        .w    (w),
        .y    (y_p),
        .valid(valid_p),
        .err  (err_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, then sample 1 time unit after the edge.
    // Expected values: strict y/valid/err, then priority y/valid/err.
    task automatic step(input string tag, input logic r, input logic en, input logic [3:0] wv,
                        input logic [1:0] ys, input logic vs, input logic es,
                        input logic [1:0] yp, input logic vp, input logic ep);
        rst = r;
        e   = en;
        w   = wv;
        @(posedge clk);
        #1;
        check1({tag, " strict.y"},     y_s,             ys);
        check1({tag, " strict.valid"}, {1'b0, valid_s}, {1'b0, vs});
        check1({tag, " strict.err"},   {1'b0, err_s},   {1'b0, es});
        check1({tag, " prio.y"},       y_p,             yp);
        check1({tag, " prio.valid"},   {1'b0, valid_p}, {1'b0, vp});
        check1({tag, " prio.err"},     {1'b0, err_p},   {1'b0, ep});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        e        = 1'b0;
        w        = 4'b1110;
        @(negedge clk);

        // Reset held two cycles with an active request present.
        step("rst0", 1'b1, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Enabled one-hot sweep.
        step("oh0", 1'b0, 1'b0, 4'b1110, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        step("oh1", 1'b0, 1'b0, 4'b1101, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        step("oh2", 1'b0, 1'b0, 4'b1011, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
        step("oh3", 1'b0, 1'b0, 4'b0111, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);

        // Idle.
        step("idle", 1'b0, 1'b0, 4'b1111, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Disabled sweep, including a multi-hot pattern.
        step("dis0", 1'b0, 1'b1, 4'b1110, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        step("dis1", 1'b0, 1'b1, 4'b1101, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        step("dis2", 1'b0, 1'b1, 4'b1011, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        step("dis3", 1'b0, 1'b1, 4'b0111, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        step("disI", 1'b0, 1'b1, 4'b1111, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        step("disM", 1'b0, 1'b1, 4'b0110, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Multi-hot: strict flags only, priority encodes highest active bit.
        step("mh30", 1'b0, 1'b0, 4'b0110, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
        step("mh10", 1'b0, 1'b0, 4'b1100, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1);
        step("mh20", 1'b0, 1'b0, 4'b1010, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
        step("mh21", 1'b0, 1'b0, 4'b1001, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
        step("mhAll", 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
        step("mhBack", 1'b0, 1'b0, 4'b1011, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);

        // Reset mid-operation.
        step("midA", 1'b0, 1'b0, 4'b0111, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
        step("midR", 1'b1, 1'b0, 4'b0111, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        step("midB", 1'b0, 1'b0, 4'b0111, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);

        // Reset wins over a multi-hot enabled pattern.
        step("rstM", 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
